// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler
//   Oversampling front end for a UART receiver. The raw serial line is
//   synchronised into the sampler clock domain. Each group of OVERSAMPLE
//   consecutive samples is majority-voted into one bit. Status flags report
//   noisy windows, the polarity of the first window (start bit check), and
//   long runs of zero windows (line break).
//
// Parameters
//   OVERSAMPLE    samples per bit window (3..16)
//   SYNC_STAGES   synchroniser depth on RxWire (2..4)
//   BREAK_WINDOWS consecutive 0-vote windows that flag a break (1..15)
//
// Ports
//   RxSamplerClockEnable  in   sampler clock, rising edge
//   RxSamplerReset        in   asynchronous reset, active low
//   RxWire                in   raw serial line (asynchronous)
//   BitValue              out  majority level of the last completed window
//   BitReady              out  one-cycle pulse after each completed window
//   BitNoise              out  last completed window was not unanimous
//   StartValid            out  sticky: first window after reset voted 0
//   StartError            out  sticky: first window after reset voted 1
//   BreakDetect           out  sticky: BREAK_WINDOWS zero windows in a row
//   BitCount              out  completed windows since reset, saturates at 15
module uart_rx_bit_sampler #(
  parameter int OVERSAMPLE    = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int BREAK_WINDOWS = 10
) (
  input  logic       RxSamplerClockEnable,
  input  logic       RxSamplerReset,
  input  logic       RxWire,
  output logic       BitValue,
  output logic       BitReady,
  output logic       BitNoise,
  output logic       StartValid,
  output logic       StartError,
  output logic       BreakDetect,
  output logic [3:0] BitCount
);

  localparam int PW = $clog2(OVERSAMPLE);

  logic [SYNC_STAGES-1:0] syncChain;
  logic                   syncOut;
  logic [OVERSAMPLE-1:0]  window;
  logic [PW-1:0]          phase;
  logic [4:0]             onesCnt;
  logic [4:0]             onesNext;
  logic [5:0]             twiceOnes;
  logic [3:0]             zeroRun;
  logic [3:0]             zeroRunNext;
  logic                   windowDone;
  logic                   vote;
  logic                   noise;
  logic                   firstSeen;

  assign syncOut = syncChain[SYNC_STAGES-1];

  // onesCnt tracks the popcount of the window register. Each edge the new
  // sample enters and the oldest (MSB) leaves, so the count after the shift
  // is available without a full adder tree. Width 5 covers OVERSAMPLE=16.
  assign onesNext   = onesCnt + {4'b0, syncOut} - {4'b0, window[OVERSAMPLE-1]};
  assign twiceOnes  = {onesNext, 1'b0};
  assign windowDone = (phase == PW'(OVERSAMPLE - 1));

  // Ties on even OVERSAMPLE go to 1, the idle line level.
  assign vote  = (twiceOnes >= 6'(OVERSAMPLE));
  assign noise = (onesNext != 5'd0) && (onesNext != 5'(OVERSAMPLE));

  assign zeroRunNext = vote ? 4'd0 :
                       (zeroRun == 4'd15) ? 4'd15 : zeroRun + 4'd1;

  assign firstSeen = StartValid | StartError;

  // Synchroniser, sample window, running popcount and phase.
  always_ff @(posedge RxSamplerClockEnable or negedge RxSamplerReset) begin
    if (!RxSamplerReset) begin
      syncChain <= '0;
      window    <= '0;
      onesCnt   <= '0;
      phase     <= '0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], RxWire};
      window    <= {window[OVERSAMPLE-2:0], syncOut};
      onesCnt   <= onesNext;
      phase     <= windowDone ? '0 : phase + PW'(1);
    end
  end

  // Per-window results; held stable between completions.
  always_ff @(posedge RxSamplerClockEnable or negedge RxSamplerReset) begin
    if (!RxSamplerReset) begin
      BitReady <= 1'b0;
      BitValue <= 1'b1;
      BitNoise <= 1'b0;
      BitCount <= 4'd0;
    end else begin
      BitReady <= windowDone;
      if (windowDone) begin
        BitValue <= vote;
        BitNoise <= noise;
        if (BitCount != 4'd15) BitCount <= BitCount + 4'd1;
      end
    end
  end

  // Sticky status: start polarity of the first window and line break.
  always_ff @(posedge RxSamplerClockEnable or negedge RxSamplerReset) begin
    if (!RxSamplerReset) begin
      StartValid  <= 1'b0;
      StartError  <= 1'b0;
      BreakDetect <= 1'b0;
      zeroRun     <= 4'd0;
    end else if (windowDone) begin
      zeroRun <= zeroRunNext;
      if (zeroRunNext >= 4'(BREAK_WINDOWS)) BreakDetect <= 1'b1;
      if (!firstSeen) begin
        StartValid <= ~vote;
        StartError <= vote;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
module tb_uart_rx_bit_sampler;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic rxWire = 1'b0;

  logic v3, r3, n3, sv3, se3, b3;
  logic [3:0] c3;
  logic v4, r4, n4, sv4, se4, b4;
  logic [3:0] c4;

  uart_rx_bit_sampler #(.OVERSAMPLE(3), .SYNC_STAGES(2), .BREAK_WINDOWS(10)) dut3 (
    .RxSamplerClockEnable(clk), .RxSamplerReset(rstN), .RxWire(rxWire),
    .BitValue(v3), .BitReady(r3), .BitNoise(n3), .StartValid(sv3),
    .StartError(se3), .BreakDetect(b3), .BitCount(c3));

  uart_rx_bit_sampler #(.OVERSAMPLE(4), .SYNC_STAGES(2), .BREAK_WINDOWS(5)) dut4 (
    .RxSamplerClockEnable(clk), .RxSamplerReset(rstN), .RxWire(rxWire),
    .BitValue(v4), .BitReady(r4), .BitNoise(n4), .StartValid(sv4),
    .StartError(se4), .BreakDetect(b4), .BitCount(c4));

  always #5 clk = ~clk;

  wire [9:0] got3 = {v3, r3, n3, sv3, se3, b3, c3};
  wire [9:0] got4 = {v4, r4, n4, sv4, se4, b4, c4};

  localparam logic [9:0] RST_VEC = 10'b1000000000;

  int errors = 0;
  int checks = 0;

  // Reference model: the line level seen at each edge since release.
  bit hist[$];
  int t = 0;

  // Sample entering the window at edge j (1-based): the line level from
  // s edges earlier, or the reset value 0 before the synchroniser fills.
  function automatic bit samp(int j, int s);
    if (j > s) return hist[j-s-1];
    return 1'b0;
  endfunction

  // Expected outputs after t edges, recomputed from the whole history:
  // split samples into windows of n, vote each, derive the flags.
  function automatic logic [9:0] expOut(int n, int s, int b);
    int w = t / n;
    int run = 0;
    int ones;
    bit val = 1'b1, nz = 1'b0, sv = 1'b0, se = 1'b0, brk = 1'b0, rdy;
    for (int k = 1; k <= w; k++) begin
      ones = 0;
      for (int j = (k-1)*n + 1; j <= k*n; j++) ones += int'(samp(j, s));
      val = (2*ones >= n);
      nz  = (ones != 0) && (ones != n);
      if (k == 1) begin sv = !val; se = val; end
      run = val ? 0 : run + 1;
      if (run >= b) brk = 1'b1;
    end
    rdy = (t > 0) && (t % n == 0);
    return {val, rdy, nz, sv, se, brk, 4'(w > 15 ? 15 : w)};
  endfunction

  task automatic stepEdge(input bit w);
    rxWire = w;
    @(posedge clk);
    hist.push_back(w);
    t++;
    @(negedge clk);
  endtask

  task automatic assertReset();
    rstN = 1'b0;
    hist.delete();
    t = 0;
  endtask

  task automatic releaseReset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rxWire = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (got3 !== RST_VEC) begin errors++; $display("FAIL reset_dut3 got=%b want=%b", got3, RST_VEC); end
      checks++;
      if (got4 !== RST_VEC) begin errors++; $display("FAIL reset_dut4 got=%b want=%b", got4, RST_VEC); end
    end
  endtask

  task automatic test_all_zero();
    assertReset();
    releaseReset();
    for (int e = 1; e <= 9; e++) begin
      stepEdge(1'b0);
      checks++;
      if (r3 !== 1'(e % 3 == 0)) begin errors++; $display("FAIL zero_ready edge=%0d got=%b want=%b", e, r3, e % 3 == 0); end
      if (e == 3) begin
        checks++;
        if ({v3, n3, sv3, se3} !== 4'b0010) begin
          errors++; $display("FAIL zero_first got=%b want=0010", {v3, n3, sv3, se3});
        end
      end
    end
  endtask

  task automatic test_all_one();
    assertReset();
    releaseReset();
    for (int e = 1; e <= 6; e++) begin
      stepEdge(1'b1);
      if (e == 3) begin
        checks++;
        if ({v3, r3, n3, sv3, se3} !== 5'b01110) begin
          errors++; $display("FAIL one_win1 got=%b want=01110", {v3, r3, n3, sv3, se3});
        end
      end
      if (e == 4) begin
        // four-sample window holds two 1s: tie resolves to 1, noisy, start error
        checks++;
        if ({v4, r4, n4, sv4, se4} !== 5'b11101) begin
          errors++; $display("FAIL one_os4_tie got=%b want=11101", {v4, r4, n4, sv4, se4});
        end
      end
      if (e == 6) begin
        checks++;
        if ({v3, r3, n3, c3} !== 7'b1100010) begin
          errors++; $display("FAIL one_win2 got=%b want=1100010", {v3, r3, n3, c3});
        end
      end
    end
  endtask

  task automatic test_break();
    assertReset();
    releaseReset();
    for (int e = 1; e <= 30; e++) begin
      stepEdge(1'b0);
      if (e == 19 || e == 20) begin
        checks++;
        if (b4 !== 1'(e == 20)) begin errors++; $display("FAIL break_os4 edge=%0d got=%b want=%b", e, b4, e == 20); end
      end
      if (e == 29) begin
        checks++;
        if (b3 !== 1'b0) begin errors++; $display("FAIL break_early got=%b want=0", b3); end
      end
    end
    checks++;
    if ({b3, r3, c3} !== 6'b111010) begin
      errors++; $display("FAIL break_edge30 got=%b want=111010", {b3, r3, c3});
    end
    for (int e = 0; e < 6; e++) stepEdge(1'b1);
    checks++;
    if ({b3, b4, v3} !== 3'b111) begin
      errors++; $display("FAIL break_sticky got=%b want=111", {b3, b4, v3});
    end
  endtask

  task automatic test_mid_reset();
    assertReset();
    releaseReset();
    stepEdge(1'b1);
    stepEdge(1'b1);
    assertReset();
    #1;
    checks++;
    if (got3 !== RST_VEC) begin errors++; $display("FAIL midrst_w1 got=%b want=%b", got3, RST_VEC); end
    releaseReset();
    for (int e = 1; e <= 5; e++) begin
      stepEdge(1'b1);
      if (e == 3) begin
        checks++;
        if ({sv3, se3, sv4, se4} !== 4'b1000) begin
          errors++; $display("FAIL midrst_first3 got=%b want=1000", {sv3, se3, sv4, se4});
        end
      end
      if (e == 4) begin
        checks++;
        if ({v4, sv4, se4} !== 3'b101) begin
          errors++; $display("FAIL midrst_first4 got=%b want=101", {v4, sv4, se4});
        end
      end
    end
    // second assertion lands mid-window with sticky flags already set
    assertReset();
    #1;
    checks++;
    if (got3 !== RST_VEC) begin errors++; $display("FAIL midrst_async3 got=%b want=%b", got3, RST_VEC); end
    checks++;
    if (got4 !== RST_VEC) begin errors++; $display("FAIL midrst_async4 got=%b want=%b", got4, RST_VEC); end
    for (int i = 0; i < 4; i++) begin
      rxWire = 1'b1;
      @(negedge clk);
      checks++;
      if ({got3, got4} !== {RST_VEC, RST_VEC}) begin
        errors++; $display("FAIL midrst_hold got=%b/%b want=%b", got3, got4, RST_VEC);
      end
    end
  endtask

  task automatic test_saturate();
    assertReset();
    releaseReset();
    for (int e = 1; e <= 160; e++) begin
      stepEdge(1'($urandom_range(0, 1)));
      if (e == 56) begin
        checks++;
        if (c4 !== 4'd14) begin errors++; $display("FAIL sat_56 got=%0d want=14", c4); end
      end
      if (e == 60) begin
        checks++;
        if (c4 !== 4'd15) begin errors++; $display("FAIL sat_60 got=%0d want=15", c4); end
      end
    end
    checks++;
    if ({c3, c4} !== 8'hff) begin errors++; $display("FAIL sat_160 got=%h want=ff", {c3, c4}); end
  endtask

  task automatic test_random();
    logic [9:0] exp3, exp4;
    bit lvl;
    int run, len;
    for (int sess = 0; sess < 5; sess++) begin
      assertReset();
      releaseReset();
      len = $urandom_range(90, 150);
      while (t < len) begin
        lvl = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 8);
        if ($urandom_range(0, 7) == 0) begin lvl = 1'b0; run = 35; end
        for (int i = 0; i < run && t < len; i++) begin
          stepEdge(lvl ^ 1'($urandom_range(0, 9) == 0));
          exp3 = expOut(3, 2, 10);
          exp4 = expOut(4, 2, 5);
          checks++;
          if (got3 !== exp3) begin errors++; $display("FAIL rand3 s=%0d t=%0d got=%b want=%b", sess, t, got3, exp3); end
          checks++;
          if (got4 !== exp4) begin errors++; $display("FAIL rand4 s=%0d t=%0d got=%b want=%b", sess, t, got4, exp4); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_all_one();
    test_break();
    test_mid_reset();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_sampler.md
UART_RX_BIT_SAMPLER -- requirements
Module: uart_rx_bit_sampler

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 3, samples per bit window (legal 3..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, RxWire synchronizer depth (legal 2..4).
REQ-003 SHALL have parameter BREAK_WINDOWS, default 10, consecutive 0-majority windows that flag a line break (legal 1..15).
REQ-004 SHALL have port RxSamplerClockEnable  input  1  sampler clock; all state changes on its rising edge.
REQ-005 SHALL have port RxSamplerReset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port RxWire  input  1  raw serial line, asynchronous to the sampler clock.
REQ-007 SHALL have port BitValue  output  1  majority-voted level of the last completed window.
REQ-008 SHALL have port BitReady  output  1  high for exactly one sampler period after each completed window.
REQ-009 SHALL have port BitNoise  output  1  last completed window was not unanimous.
REQ-010 SHALL have port StartValid  output  1  sticky; first window after reset voted 0.
REQ-011 SHALL have port StartError  output  1  sticky; first window after reset voted 1.
REQ-012 SHALL have port BreakDetect  output  1  sticky; BREAK_WINDOWS consecutive 0-majority windows seen.
REQ-013 SHALL have port BitCount  output  4  completed windows since reset, saturating at 15.

Function
REQ-014 SHALL pass RxWire through a SYNC_STAGES flip-flop chain; the level on RxWire at edge k enters the sample window at edge k+SYNC_STAGES.
REQ-015 SHALL shift the synchronizer output into an OVERSAMPLE-bit window register on every edge.
REQ-016 SHALL keep phase counter Phase, 0..OVERSAMPLE-1, incrementing every edge and wrapping OVERSAMPLE-1 -> 0.
REQ-017 SHALL, on the edge where Phase==OVERSAMPLE-1, treat the window (including the sample shifted in at that edge) as complete.
REQ-018 SHALL, at window completion, register BitValue = 1 iff 2*ones >= OVERSAMPLE (even-N ties resolve to 1, idle level).
REQ-019 SHALL, at window completion, register BitNoise = 1 iff ones is neither 0 nor OVERSAMPLE.
REQ-020 SHALL register BitReady = 1 on completion edges and 0 on all other edges; BitValue/BitNoise hold stable while BitReady is high.
REQ-021 SHALL, on the first completion after reset only, set StartValid if the vote is 0, else StartError; exactly one of the two ever sets per reset.
REQ-022 SHALL count consecutive 0-vote windows in a 4-bit counter, clear it on any 1-vote window, and set BreakDetect when it reaches BREAK_WINDOWS; BreakDetect is not cleared by a later 1-vote.
REQ-023 SHALL saturate the zero-run counter at 15 and BitCount at 15 (no wrap).
REQ-024 SHALL compute ones with a width sufficient for OVERSAMPLE=16 (5 bits) without truncation.

Reset
REQ-025 SHALL, while RxSamplerReset is low, force: synchronizer and window to all 0 (reset is released after a start edge), Phase=0, BitReady=0, BitValue=1, BitNoise=0, StartValid=0, StartError=0, BreakDetect=0, BitCount=0, zero-run counter=0.
REQ-026 SHALL apply reset immediately (asynchronously) including mid-window; the partial window is discarded and the first full window after release is again the "first window".
REQ-027 SHALL release reset synchronously to nothing else; first counted edge is the first rising edge with RxSamplerReset high.

Verification (OVERSAMPLE=3, SYNC_STAGES=2 unless stated)
REQ-028 SHALL verify: RxWire=0 from release -> BitReady pulses after edges 3,6,9..; first window BitValue=0, BitNoise=0, StartValid=1, StartError=0.
REQ-029 SHALL verify: RxWire=1 from release -> window1 ones=1 -> BitValue=0, BitNoise=1, StartValid=1; window2 -> BitValue=1, BitNoise=0; BitCount=2.
REQ-030 SHALL verify: RxWire=0 for 30 edges -> BreakDetect rises with the 10th BitReady (edge 30), BitCount=10; then RxWire=1 -> BreakDetect stays 1.
REQ-031 SHALL verify: reset asserted after edge 2 of window1, released, RxWire=1 -> BitReady=0 during reset, all outputs at reset values, StartError=1 only after first full new window voting 1.
REQ-032 SHALL verify: OVERSAMPLE=4, window containing two 1s -> BitValue=1, BitNoise=1; 40 windows -> BitCount holds 15.
